csr_trap_ctrl: RTL and testbench
================================

Name: csr_trap_ctrl

Overview:
- Producer side of the CSR/GPR write interface of the architectural register file.
- Sits at writeback. Accepts one retiring system instruction per handshake: CSRRW/CSRRS/CSRRC, ECALL or MRET.
- Sequences the CSR write strobes (wbcsren plus wb* data) and the GPR write (io_waddr/io_wdata/io_wen). Raises a PC redirect for traps and MRET.
- Also takes the machine timer interrupt and mirrors MTIP into mip.

Parameters:
- XLEN, 64, datapath width.
- MCAUSE_ECALL, 64'd11, cause code for ECALL from M-mode.
- MCAUSE_MTI, 64'h8000_0000_0000_0007, cause code for the machine timer interrupt.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  system-instruction request.
- in_ready  out  1  high only in IDLE.
- in_op  in  3  0=NOP, 1=CSRRW, 2=CSRRS, 3=CSRRC, 4=ECALL, 5=MRET.
- in_csr  in  12  CSR address.
- in_rs1  in  5  rs1 index; used only for write suppression.
- in_src  in  64  rs1 value.
- in_rd  in  5  destination GPR.
- in_pc  in  64  PC of the instruction.
- mtip  in  1  timer interrupt level.
- mepc, mcause, mtvec, mstatus, mie, mip  in  64 each  current CSR values.
- wbmepc, wbmcause, wbmtvec, wbmstatus, wbmie, wbmip  out  64 each  CSR write data.
- wbcsren  out  8  write strobes: bit0 mepc, bit1 mcause, bit2 mtvec, bit3 mstatus, bit4 mie, bit5 mip; bits 7:6 always 0.
- io_waddr  out  5  GPR write address.
- io_wdata  out  64  GPR write data.
- io_wen  out  1  GPR write enable.
- redirect_valid  out  1  one-cycle PC redirect pulse.
- redirect_pc  out  64  redirect target.

Behaviour:
- States: IDLE, CSR_WB, TRAP_SAVE, TRAP_STAT, MRET_WB.
- All outputs are registered. Reset forces IDLE and clears wbcsren, io_wen and redirect_valid. All data outputs reset to 0.
- Acceptance: a request is accepted when in_valid && in_ready in IDLE. The accepted fields and the selected old CSR value are latched.
- Interrupt pending: pend = mstatus[3] && mie[7] && mip[7].
- Priority at acceptance:
  - pend overrides any in_op. The instruction is discarded. Latch cause=MCAUSE_MTI, epc=in_pc. Go to TRAP_SAVE.
  - Otherwise ECALL goes to TRAP_SAVE with MCAUSE_ECALL.
  - MRET goes to MRET_WB.
  - CSRRW/S/C goes to CSR_WB.
  - NOP is consumed with no effect.
- CSR_WB (1 cycle, then IDLE):
  - new = src (W), old|src (S), old&~src (C). The strobe for the mapped CSR is pulsed.
  - CSR map: 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0x344 mip.
  - S/C with in_rs1==0 produce no CSR strobe.
  - An unmapped address reads 0 and writes nothing.
  - io_wen = (in_rd!=0), io_waddr = in_rd, io_wdata = old.
- TRAP_SAVE (1 cycle):
  - wbcsren[0] and wbcsren[1] pulse, with wbmepc=epc and wbmcause=cause.
  - Next state TRAP_STAT.
- TRAP_STAT (1 cycle):
  - wbmstatus = mstatus with MPIE(bit7)<=MIE(bit3), MIE<=0, MPP(12:11)<=2'b11. wbcsren[3] pulses.
  - redirect_valid=1, redirect_pc = {mtvec[63:2],2'b00}.
  - Next state IDLE.
- MRET_WB (1 cycle):
  - wbmstatus sets MIE<=MPIE, MPIE<=1, MPP<=2'b11. wbcsren[3] pulses.
  - redirect_valid=1, redirect_pc=mepc.
  - Next state IDLE.
- Latency: CSR op takes 1 cycle after acceptance; trap takes 2 cycles to redirect; MRET takes 1 cycle.
- MTIP mirroring:
  - In any cycle where mip[7] != mtip, pulse wbcsren[5] with wbmip = {mip[63:8], mtip, mip[6:0]}.
  - A software write to mip in CSR_WB in the same cycle merges: bit7 is forced to mtip, other bits come from the write.
- Read-after-write: CSR writes land at the edge ending the write state. IDLE therefore always sees updated values, so no bypass is required.
- Reset mid-sequence (e.g. in TRAP_SAVE): the sequence is abandoned, no redirect is issued, and the state returns to IDLE.

Decomposition:
- Shared package holds:
  - op encodings (OP_NOP..OP_MRET)
  - CSR address constants
  - wbcsren bit indices
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11)
  - MTIP/MTIE bit 7
  - cause constants
- One natural sub-module, csr_alu: combinational CSR address decode, old-value mux and W/S/C result computation.

Test Plan:
- CSRRW csr=0x305 src=0x8000_0100 rd=5, old mtvec=0 -> next cycle wbcsren=0x04, wbmtvec=0x8000_0100, io_wen=1, io_waddr=5, io_wdata=0.
- CSRRS csr=0x300 rs1=0 rd=7, mstatus=0xA00001800 -> wbcsren=0, io_wdata=0xA00001800, io_wen=1.
- ECALL pc=0x8000_0040, mstatus=0xA00001808, mtvec=0x8000_0100 -> cycle1: wbcsren=0x03, wbmepc=0x8000_0040, wbmcause=11. Cycle2: wbcsren=0x08, wbmstatus=0xA00001880, redirect_pc=0x8000_0100. in_ready low for 2 cycles.
- MRET with mstatus=0xA00001880, mepc=0x8000_0044 -> wbmstatus=0xA00001888, redirect_valid=1, redirect_pc=0x8000_0044.
- mtip rises with mip=0, then CSRRW request while mstatus.MIE=1 and mie=0x80 -> wbcsren[5] pulse, wbmip=0x80. The next request is discarded, wbmcause=0x8000_0000_0000_0007, wbmepc=in_pc, and io_wen stays 0.
- reset asserted in TRAP_SAVE -> next cycle IDLE, in_ready=1, wbcsren=0, redirect_valid never asserted.

Source files
------------

// File: rtl/csr_trap_ctrl_pkg.sv
// Shared encodings, CSR map, strobe layout and mstatus helpers for the trap/CSR writeback controller.
package csr_trap_ctrl_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned CSR_W   = 12;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned STB_W   = 8;

    localparam logic [XLEN-1:0] MCAUSE_ECALL = 64'd11;
    localparam logic [XLEN-1:0] MCAUSE_MTI   = 64'h8000_0000_0000_0007;

    // System-instruction opcodes as delivered by the decoder.
    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 3'd0,
        OP_CSRRW = 3'd1,
        OP_CSRRS = 3'd2,
        OP_CSRRC = 3'd3,
        OP_ECALL = 3'd4,
        OP_MRET  = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CSR_WB    = 3'd1,
        TRAP_SAVE = 3'd2,
        TRAP_STAT = 3'd3,
        MRET_WB   = 3'd4
    } state_e;

    localparam logic [CSR_W-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_W-1:0] CSR_MIE     = 12'h304;
    localparam logic [CSR_W-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_W-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_W-1:0] CSR_MCAUSE  = 12'h342;
    localparam logic [CSR_W-1:0] CSR_MIP     = 12'h344;

    // wbcsren bit positions
    localparam int unsigned WB_MEPC    = 0;
    localparam int unsigned WB_MCAUSE  = 1;
    localparam int unsigned WB_MTVEC   = 2;
    localparam int unsigned WB_MSTATUS = 3;
    localparam int unsigned WB_MIE     = 4;
    localparam int unsigned WB_MIP     = 5;

    localparam logic [STB_W-1:0] STB_MEPC    = 8'h01;
    localparam logic [STB_W-1:0] STB_MCAUSE  = 8'h02;
    localparam logic [STB_W-1:0] STB_MTVEC   = 8'h04;
    localparam logic [STB_W-1:0] STB_MSTATUS = 8'h08;
    localparam logic [STB_W-1:0] STB_MIE     = 8'h10;
    localparam logic [STB_W-1:0] STB_MIP     = 8'h20;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;
    localparam int unsigned MIP_MTIP       = 7;
    localparam int unsigned MIE_MTIE       = 7;

    // mstatus after trap entry: stack MIE into MPIE, disable, record M-mode.
    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // mstatus after MRET: restore MIE from MPIE, set MPIE, MPP stays M.
    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // Replace the MTIP bit of an mip value with the live timer level.
    function automatic logic [XLEN-1:0] with_mtip(input logic [XLEN-1:0] v, input logic b);
        logic [XLEN-1:0] r;
        r = v;
        r[MIP_MTIP] = b;
        return r;
    endfunction

endpackage

// File: rtl/csr_trap_ctrl_csr_alu.sv
// CSR address decode, old-value select and CSRRW/S/C result with write suppression.
module csr_alu
    import csr_trap_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    input  logic [CSR_W-1:0] csr,
    input  logic [REG_W-1:0] rs1,
    input  logic [XLEN-1:0]  src,
    input  logic [XLEN-1:0]  mepc,
    input  logic [XLEN-1:0]  mcause,
    input  logic [XLEN-1:0]  mtvec,
    input  logic [XLEN-1:0]  mstatus,
    input  logic [XLEN-1:0]  mie,
    input  logic [XLEN-1:0]  mip,
    output logic [XLEN-1:0]  old_c,
    output logic [XLEN-1:0]  new_c,
    output logic [STB_W-1:0] wmask_c
);

    logic [STB_W-1:0] sel;
    logic             wr;

    // Decode, read mux and read-modify-write result.
    always_comb begin
        old_c   = '0;
        sel     = '0;
        new_c   = '0;
        wr      = 1'b0;
        wmask_c = '0;
        case (csr)
            CSR_MSTATUS: begin old_c = mstatus; sel = STB_MSTATUS; end
            CSR_MIE:     begin old_c = mie;     sel = STB_MIE;     end
            CSR_MTVEC:   begin old_c = mtvec;   sel = STB_MTVEC;   end
            CSR_MEPC:    begin old_c = mepc;    sel = STB_MEPC;    end
            CSR_MCAUSE:  begin old_c = mcause;  sel = STB_MCAUSE;  end
            CSR_MIP:     begin old_c = mip;     sel = STB_MIP;     end
            default:     ;
        endcase
        case (op)
            OP_CSRRW: begin new_c = src;           wr = 1'b1;             end
            OP_CSRRS: begin new_c = old_c | src;   wr = (rs1 != '0);      end
            OP_CSRRC: begin new_c = old_c & ~src;  wr = (rs1 != '0);      end
            default:  begin new_c = old_c;         wr = 1'b0;             end
        endcase
        wmask_c = wr ? sel : '0;
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Writeback-stage sequencer for CSR ops, ECALL/timer traps and MRET, plus MTIP mirroring into mip.
module csr_trap_ctrl
    import csr_trap_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [CSR_W-1:0] in_csr,
    input  logic [REG_W-1:0] in_rs1,
    input  logic [XLEN-1:0]  in_src,
    input  logic [REG_W-1:0] in_rd,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             mtip,
    input  logic [XLEN-1:0]  mepc,
    input  logic [XLEN-1:0]  mcause,
    input  logic [XLEN-1:0]  mtvec,
    input  logic [XLEN-1:0]  mstatus,
    input  logic [XLEN-1:0]  mie,
    input  logic [XLEN-1:0]  mip,
    output logic [XLEN-1:0]  wbmepc,
    output logic [XLEN-1:0]  wbmcause,
    output logic [XLEN-1:0]  wbmtvec,
    output logic [XLEN-1:0]  wbmstatus,
    output logic [XLEN-1:0]  wbmie,
    output logic [XLEN-1:0]  wbmip,
    output logic [STB_W-1:0] wbcsren,
    output logic [REG_W-1:0] io_waddr,
    output logic [XLEN-1:0]  io_wdata,
    output logic             io_wen,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc
);

    state_e           state;
    logic [XLEN-1:0]  alu_old_c;
    logic [XLEN-1:0]  alu_new_c;
    logic [STB_W-1:0] alu_wmask_c;
    logic [STB_W-1:0] mirror_c;
    logic             accept_c;
    logic             pend_c;

    csr_alu u_csr_alu (
        .op      (in_op),
        .csr     (in_csr),
        .rs1     (in_rs1),
        .src     (in_src),
        .mepc    (mepc),
        .mcause  (mcause),
        .mtvec   (mtvec),
        .mstatus (mstatus),
        .mie     (mie),
        .mip     (mip),
        .old_c   (alu_old_c),
        .new_c   (alu_new_c),
        .wmask_c (alu_wmask_c)
    );

    // in_ready is a registered copy of (state == IDLE).
    assign accept_c = in_valid && in_ready;
    assign pend_c   = mstatus[MSTATUS_MIE] && mie[MIE_MTIE] && mip[MIP_MTIP];
    assign mirror_c = (mip[MIP_MTIP] != mtip) ? STB_MIP : '0;

    // Sequencer: outputs are registered at the edge entering the state that presents them.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            in_ready       <= 1'b1;
            wbcsren        <= '0;
            wbmepc         <= '0;
            wbmcause       <= '0;
            wbmtvec        <= '0;
            wbmstatus      <= '0;
            wbmie          <= '0;
            wbmip          <= '0;
            io_waddr       <= '0;
            io_wdata       <= '0;
            io_wen         <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            wbcsren        <= mirror_c;
            io_wen         <= 1'b0;
            redirect_valid <= 1'b0;
            if (mirror_c[WB_MIP]) begin
                wbmip <= with_mtip(mip, mtip);
            end
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        if (pend_c) begin
                            wbcsren  <= mirror_c | STB_MEPC | STB_MCAUSE;
                            wbmepc   <= in_pc;
                            wbmcause <= MCAUSE_MTI;
                            in_ready <= 1'b0;
                            state    <= TRAP_SAVE;
                        end else begin
                            case (in_op)
                                OP_ECALL: begin
                                    wbcsren  <= mirror_c | STB_MEPC | STB_MCAUSE;
                                    wbmepc   <= in_pc;
                                    wbmcause <= MCAUSE_ECALL;
                                    in_ready <= 1'b0;
                                    state    <= TRAP_SAVE;
                                end
                                OP_MRET: begin
                                    wbcsren        <= mirror_c | STB_MSTATUS;
                                    wbmstatus      <= mret_mstatus(mstatus);
                                    redirect_valid <= 1'b1;
                                    redirect_pc    <= mepc;
                                    in_ready       <= 1'b0;
                                    state          <= MRET_WB;
                                end
                                OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
                                    wbcsren <= mirror_c | alu_wmask_c;
                                    if (alu_wmask_c[WB_MEPC])    wbmepc    <= alu_new_c;
                                    if (alu_wmask_c[WB_MCAUSE])  wbmcause  <= alu_new_c;
                                    if (alu_wmask_c[WB_MTVEC])   wbmtvec   <= alu_new_c;
                                    if (alu_wmask_c[WB_MSTATUS]) wbmstatus <= alu_new_c;
                                    if (alu_wmask_c[WB_MIE])     wbmie     <= alu_new_c;
                                    if (alu_wmask_c[WB_MIP])     wbmip     <= with_mtip(alu_new_c, mtip);
                                    io_wen   <= (in_rd != '0);
                                    io_waddr <= in_rd;
                                    io_wdata <= alu_old_c;
                                    in_ready <= 1'b0;
                                    state    <= CSR_WB;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                TRAP_SAVE: begin
                    wbcsren        <= mirror_c | STB_MSTATUS;
                    wbmstatus      <= trap_mstatus(mstatus);
                    redirect_valid <= 1'b1;
                    redirect_pc    <= {mtvec[XLEN-1:2], 2'b00};
                    state          <= TRAP_STAT;
                end
                TRAP_STAT, CSR_WB, MRET_WB: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl: CSR ops, ECALL, MRET, timer interrupt, mip merge, reset mid-trap.
module tb_csr_trap_ctrl;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [11:0] in_csr;
    logic [4:0]  in_rs1;
    logic [63:0] in_src;
    logic [4:0]  in_rd;
    logic [63:0] in_pc;
    logic        mtip;
    logic [63:0] mepc, mcause, mtvec, mstatus, mie, mip;
    logic [63:0] wbmepc, wbmcause, wbmtvec, wbmstatus, wbmie, wbmip;
    logic [7:0]  wbcsren;
    logic [4:0]  io_waddr;
    logic [63:0] io_wdata;
    logic        io_wen;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int vectors;
    int miscompares;

    csr_trap_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_csr         (in_csr),
        .in_rs1         (in_rs1),
        .in_src         (in_src),
        .in_rd          (in_rd),
        .in_pc          (in_pc),
        .mtip           (mtip),
        .mepc           (mepc),
        .mcause         (mcause),
        .mtvec          (mtvec),
        .mstatus        (mstatus),
        .mie            (mie),
        .mip            (mip),
        .wbmepc         (wbmepc),
        .wbmcause       (wbmcause),
        .wbmtvec        (wbmtvec),
        .wbmstatus      (wbmstatus),
        .wbmie          (wbmie),
        .wbmip          (wbmip),
        .wbcsren        (wbcsren),
        .io_waddr       (io_waddr),
        .io_wdata       (io_wdata),
        .io_wen         (io_wen),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic req(input logic [2:0] op, input logic [11:0] csr, input logic [4:0] rs1,
                       input logic [63:0] src, input logic [4:0] rd, input logic [63:0] pc);
        in_valid = 1'b1;
        in_op    = op;
        in_csr   = csr;
        in_rs1   = rs1;
        in_src   = src;
        in_rd    = rd;
        in_pc    = pc;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        in_op = 3'd0; in_csr = '0; in_rs1 = '0; in_src = '0; in_rd = '0; in_pc = '0;
        mtip = 1'b0;
        mepc = '0; mcause = '0; mtvec = '0; mstatus = 64'hA_0000_1800; mie = '0; mip = '0;

        // reset state
        step(); step();
        chk("rst_ready",    64'(in_ready),       64'd1);
        chk("rst_csren",    64'(wbcsren),        64'd0);
        chk("rst_wen",      64'(io_wen),         64'd0);
        chk("rst_redir",    64'(redirect_valid), 64'd0);
        chk("rst_wbmstat",  wbmstatus,           64'd0);
        reset = 1'b0;
        step();

        // CSRRW mtvec
        req(3'd1, 12'h305, 5'd1, 64'h8000_0100, 5'd5, 64'h0);
        step();
        in_valid = 1'b0;
        chk("rw_csren",  64'(wbcsren),  64'h04);
        chk("rw_wbmtv",  wbmtvec,       64'h8000_0100);
        chk("rw_wen",    64'(io_wen),   64'd1);
        chk("rw_waddr",  64'(io_waddr), 64'd5);
        chk("rw_wdata",  io_wdata,      64'd0);
        chk("rw_ready",  64'(in_ready), 64'd0);
        mtvec = 64'h8000_0100;
        step();
        chk("rw_idle_ready", 64'(in_ready), 64'd1);
        chk("rw_idle_csren", 64'(wbcsren),  64'd0);
        chk("rw_idle_wen",   64'(io_wen),   64'd0);

        // CSRRS with rs1=0: read only
        req(3'd2, 12'h300, 5'd0, 64'hFF, 5'd7, 64'h0);
        step();
        in_valid = 1'b0;
        chk("rs0_csren", 64'(wbcsren),  64'd0);
        chk("rs0_wdata", io_wdata,      64'hA_0000_1800);
        chk("rs0_wen",   64'(io_wen),   64'd1);
        chk("rs0_waddr", 64'(io_waddr), 64'd7);
        step();

        // CSRRC mstatus, rd=0
        req(3'd3, 12'h300, 5'd2, 64'h800, 5'd0, 64'h0);
        step();
        in_valid = 1'b0;
        chk("rc_csren",  64'(wbcsren), 64'h08);
        chk("rc_wbmst",  wbmstatus,    64'hA_0000_1000);
        chk("rc_wen",    64'(io_wen),  64'd0);
        step();

        // CSRRW to unmapped address
        req(3'd1, 12'h340, 5'd1, 64'h5, 5'd4, 64'h0);
        step();
        in_valid = 1'b0;
        chk("um_csren", 64'(wbcsren), 64'd0);
        chk("um_wdata", io_wdata,     64'd0);
        chk("um_wen",   64'(io_wen),  64'd1);
        step();

        // ECALL
        mstatus = 64'hA_0000_1808;
        req(3'd4, 12'h0, 5'd0, 64'h0, 5'd0, 64'h8000_0040);
        step();
        in_valid = 1'b0;
        chk("ec1_csren", 64'(wbcsren),        64'h03);
        chk("ec1_mepc",  wbmepc,              64'h8000_0040);
        chk("ec1_mcau",  wbmcause,            64'd11);
        chk("ec1_ready", 64'(in_ready),       64'd0);
        chk("ec1_redir", 64'(redirect_valid), 64'd0);
        step();
        chk("ec2_csren", 64'(wbcsren),        64'h08);
        chk("ec2_mstat", wbmstatus,           64'hA_0000_1880);
        chk("ec2_redir", 64'(redirect_valid), 64'd1);
        chk("ec2_rpc",   redirect_pc,         64'h8000_0100);
        chk("ec2_ready", 64'(in_ready),       64'd0);
        step();
        chk("ec3_ready", 64'(in_ready),       64'd1);
        chk("ec3_redir", 64'(redirect_valid), 64'd0);

        // MRET
        mstatus = 64'hA_0000_1880;
        mepc = 64'h8000_0044;
        req(3'd5, 12'h0, 5'd0, 64'h0, 5'd0, 64'h0);
        step();
        in_valid = 1'b0;
        chk("mr_csren", 64'(wbcsren),        64'h08);
        chk("mr_mstat", wbmstatus,           64'hA_0000_1888);
        chk("mr_redir", 64'(redirect_valid), 64'd1);
        chk("mr_rpc",   redirect_pc,         64'h8000_0044);
        chk("mr_ready", 64'(in_ready),       64'd0);
        step();
        chk("mr_idle_ready", 64'(in_ready),       64'd1);
        chk("mr_idle_redir", 64'(redirect_valid), 64'd0);

        // NOP consumed in place
        req(3'd0, 12'h305, 5'd1, 64'h1234, 5'd3, 64'h0);
        step();
        in_valid = 1'b0;
        chk("nop_ready", 64'(in_ready), 64'd1);
        chk("nop_csren", 64'(wbcsren),  64'd0);
        chk("nop_wen",   64'(io_wen),   64'd0);

        // Software mip write merges live MTIP (mtip=1 keeps bit7 set)
        mstatus = 64'h0;
        mip = 64'h80;
        mtip = 1'b1;
        req(3'd1, 12'h344, 5'd1, 64'h5, 5'd0, 64'h0);
        step();
        in_valid = 1'b0;
        chk("mg1_csren", 64'(wbcsren), 64'h20);
        chk("mg1_wbmip", wbmip,        64'h85);
        step();
        // Merge with mtip=0 and mip[7]=1: write still pulses, bit7 cleared
        mtip = 1'b0;
        req(3'd1, 12'h344, 5'd1, 64'hFF, 5'd0, 64'h0);
        step();
        in_valid = 1'b0;
        chk("mg2_csren", 64'(wbcsren), 64'h20);
        chk("mg2_wbmip", wbmip,        64'h7F);
        mip = 64'h0;
        step();

        // Timer interrupt: mtip rises alongside a CSRRW to mie
        mstatus = 64'h8;
        mie = 64'h80;
        mip = 64'h0;
        mtvec = 64'h8000_0203;
        mtip = 1'b1;
        req(3'd1, 12'h304, 5'd1, 64'h80, 5'd3, 64'h0);
        step();
        in_valid = 1'b0;
        chk("ti1_csren", 64'(wbcsren),  64'h30);
        chk("ti1_wbmip", wbmip,         64'h80);
        chk("ti1_wbmie", wbmie,         64'h80);
        chk("ti1_wdata", io_wdata,      64'h80);
        chk("ti1_wen",   64'(io_wen),   64'd1);
        mip = 64'h80;
        step();
        chk("ti2_csren", 64'(wbcsren), 64'd0);
        // next request is discarded in favour of the interrupt
        req(3'd1, 12'h305, 5'd1, 64'h1111, 5'd9, 64'h8000_0200);
        step();
        in_valid = 1'b0;
        chk("ti3_csren", 64'(wbcsren), 64'h03);
        chk("ti3_mcau",  wbmcause,     64'h8000_0000_0000_0007);
        chk("ti3_mepc",  wbmepc,       64'h8000_0200);
        chk("ti3_wen",   64'(io_wen),  64'd0);
        step();
        chk("ti4_csren", 64'(wbcsren),        64'h08);
        chk("ti4_mstat", wbmstatus,           64'h1880);
        chk("ti4_redir", 64'(redirect_valid), 64'd1);
        chk("ti4_rpc",   redirect_pc,         64'h8000_0200);
        chk("ti4_wen",   64'(io_wen),         64'd0);
        step();
        chk("ti5_ready", 64'(in_ready), 64'd1);

        // Reset while in TRAP_SAVE abandons the trap
        mtip = 1'b0;
        mip = 64'h0;
        mie = 64'h0;
        mstatus = 64'h8;
        req(3'd4, 12'h0, 5'd0, 64'h0, 5'd0, 64'h8000_0300);
        step();
        in_valid = 1'b0;
        chk("rs1_csren", 64'(wbcsren), 64'h03);
        reset = 1'b1;
        step();
        chk("rs2_ready", 64'(in_ready),       64'd1);
        chk("rs2_csren", 64'(wbcsren),        64'd0);
        chk("rs2_redir", 64'(redirect_valid), 64'd0);
        reset = 1'b0;
        step();
        chk("rs3_redir", 64'(redirect_valid), 64'd0);
        chk("rs3_ready", 64'(in_ready),       64'd1);
        step();
        chk("rs4_redir", 64'(redirect_valid), 64'd0);
        chk("rs4_csren", 64'(wbcsren),        64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
